// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and constants for the multdiv issue/writeback controller.
package multdiv_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/md_timeout_counter.sv
// Cycle counter bounding how long the controller waits on multdiv.
module md_timeout_counter
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic at_limit_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count up while enabled; hold at the limit so the flag stays asserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_limit_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit_c = (count == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller sitting between execute and the iterative multdiv unit.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_op,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [REG_W-1:0]  issue_rd,
    output logic              issue_ready,
    input  logic              flush,
    input  logic [REG_W-1:0]  dep_rs1,
    input  logic [REG_W-1:0]  dep_rs2,
    output logic              dep_hazard,
    output logic              stall,
    output logic [DATA_W-1:0] md_operandA,
    output logic [DATA_W-1:0] md_operandB,
    output logic              md_ctrl_MULT,
    output logic              md_ctrl_DIV,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_resultRDY,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_exception,
    input  logic              wb_ack
);

    state_e             state;
    op_e                op_q;
    logic [REG_W-1:0]   rd_q;
    logic [DATA_W-1:0]  data_q;
    logic               exc_q;
    logic               cnt_clear;
    logic               cnt_enable;
    logic               cnt_last_c;
    logic               pending;

    assign cnt_clear  = (state == ST_START);
    assign cnt_enable = (state == ST_WAIT) || (state == ST_DRAIN);

    md_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .at_limit_c (cnt_last_c)
    );

    // Controller FSM with the held operand, destination and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_MULT;
            rd_q        <= REG_ZERO;
            md_operandA <= '0;
            md_operandB <= '0;
            data_q      <= '0;
            exc_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_valid && !flush) begin
                        md_operandA <= issue_a;
                        md_operandB <= issue_b;
                        op_q        <= op_e'(issue_op);
                        rd_q        <= issue_rd;
                        // Divide-by-zero is trapped here; multdiv is never started.
                        if (op_e'(issue_op) == OP_DIV && issue_b == '0) begin
                            data_q <= '0;
                            exc_q  <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    // Any ready seen here belongs to the previous op.
                    state <= flush ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (flush) begin
                        // A result landing with the flush already ends the op; nothing to drain.
                        state <= md_resultRDY ? ST_IDLE : ST_DRAIN;
                    end else if (md_resultRDY) begin
                        data_q <= md_result;
                        exc_q  <= md_exception;
                        state  <= ST_DONE;
                    end else if (cnt_last_c) begin
                        data_q <= '0;
                        exc_q  <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || wb_ack) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (md_resultRDY || cnt_last_c) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign issue_ready  = (state == ST_IDLE);
    assign md_ctrl_MULT = (state == ST_START) && (op_q == OP_MULT);
    assign md_ctrl_DIV  = (state == ST_START) && (op_q == OP_DIV);
    assign wb_valid     = (state == ST_DONE);
    assign wb_rd        = rd_q;
    assign wb_data      = data_q;
    assign wb_exception = exc_q;

    assign pending    = (state == ST_START) || (state == ST_WAIT) || (state == ST_DONE);
    assign dep_hazard = pending && (rd_q != REG_ZERO) && ((dep_rs1 == rd_q) || (dep_rs2 == rd_q));
    assign stall      = (issue_valid && !issue_ready) || dep_hazard;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl with a timeline-based reference model.
module tb_multdiv_ctrl;

    localparam int T_MAIN  = 64;
    localparam int T_SMALL = 8;
    localparam int P_ACC   = 0;
    localparam int P_START = 1;
    localparam int P_WAIT  = 2;
    localparam int P_DONE  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_op, flush, wb_ack;
    logic [31:0] issue_a, issue_b, md_result;
    logic [4:0]  issue_rd, dep_rs1, dep_rs2;
    logic        md_exception, md_resultRDY;

    logic        m_ready, m_haz, m_stall, m_mult, m_div, m_wbv, m_wbexc;
    logic [31:0] m_opa, m_opb, m_wbdata;
    logic [4:0]  m_wbrd;
    logic        t_ready, t_haz, t_stall, t_mult, t_div, t_wbv, t_wbexc;
    logic [31:0] t_opa, t_opb, t_wbdata;
    logic [4:0]  t_wbrd;

    bit sel = 1'b0;
    int checks = 0;
    int failures = 0;

    logic        o_ready, o_haz, o_stall, o_mult, o_div, o_wbv, o_wbexc;
    logic [31:0] o_opa, o_opb, o_wbdata;
    logic [4:0]  o_wbrd;

    assign o_ready  = sel ? t_ready  : m_ready;
    assign o_haz    = sel ? t_haz    : m_haz;
    assign o_stall  = sel ? t_stall  : m_stall;
    assign o_mult   = sel ? t_mult   : m_mult;
    assign o_div    = sel ? t_div    : m_div;
    assign o_wbv    = sel ? t_wbv    : m_wbv;
    assign o_wbexc  = sel ? t_wbexc  : m_wbexc;
    assign o_opa    = sel ? t_opa    : m_opa;
    assign o_opb    = sel ? t_opb    : m_opb;
    assign o_wbdata = sel ? t_wbdata : m_wbdata;
    assign o_wbrd   = sel ? t_wbrd   : m_wbrd;

    always #5 clock = ~clock;

    multdiv_ctrl #(.TIMEOUT_CYCLES(T_MAIN), .CNT_W(7)) dut_main (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .issue_ready(m_ready),
        .flush(flush), .dep_rs1(dep_rs1), .dep_rs2(dep_rs2), .dep_hazard(m_haz), .stall(m_stall),
        .md_operandA(m_opa), .md_operandB(m_opb), .md_ctrl_MULT(m_mult), .md_ctrl_DIV(m_div),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .wb_valid(m_wbv), .wb_rd(m_wbrd), .wb_data(m_wbdata), .wb_exception(m_wbexc), .wb_ack(wb_ack)
    );

    multdiv_ctrl #(.TIMEOUT_CYCLES(T_SMALL), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .issue_ready(t_ready),
        .flush(flush), .dep_rs1(dep_rs1), .dep_rs2(dep_rs2), .dep_hazard(t_haz), .stall(t_stall),
        .md_operandA(t_opa), .md_operandB(t_opb), .md_ctrl_MULT(t_mult), .md_ctrl_DIV(t_div),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .wb_valid(t_wbv), .wb_rd(t_wbrd), .wb_data(t_wbdata), .wb_exception(t_wbexc), .wb_ack(wb_ack)
    );

    function automatic logic [4:0] rnd_rs(input logic [4:0] rd);
        if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 31));
        return rd;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        issue_valid = 1'b0; issue_op = 1'b0; issue_a = '0; issue_b = '0; issue_rd = '0;
        flush = 1'b0; dep_rs1 = '0; dep_rs2 = '0; wb_ack = 1'b0;
        md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    endtask

    task automatic apply_reset();
        quiet_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // One op end to end: the expected cycle timeline is built from the op's rules, then walked.
    task automatic do_op(input bit op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input int lat, input bit mexc, input int ack_delay, input bit stale,
                         input bit busy_offer, input bit fix_dep, input logic [4:0] rs_fix);
        int T, exp_wait, wcnt, dcnt, p;
        int ph[$];
        logic [31:0] exp_data;
        logic exp_exc;
        bit div0, exp_rdy, busy, exp_haz, exp_stall, rdy_now;
        T = sel ? T_SMALL : T_MAIN;
        div0 = op && (b == 0);
        if (div0) begin
            exp_data = 0; exp_exc = 1'b1; exp_wait = 0;
        end else if (lat < 1 || lat > T) begin
            exp_data = 0; exp_exc = 1'b1; exp_wait = T;
        end else begin
            exp_data = op ? 32'($signed(a) / $signed(b)) : 32'(a * b);
            exp_exc  = mexc;
            exp_wait = lat;
        end
        ph.push_back(P_ACC);
        if (!div0) begin
            ph.push_back(P_START);
            repeat (exp_wait) ph.push_back(P_WAIT);
        end
        repeat (ack_delay + 1) ph.push_back(P_DONE);
        wcnt = 0;
        dcnt = 0;
        foreach (ph[c]) begin
            p = ph[c];
            if (c > 0) step();
            if (p == P_WAIT) wcnt++;
            if (p == P_DONE) dcnt++;
            issue_valid = (p == P_ACC) || (busy_offer && p == P_WAIT);
            if (p == P_ACC) begin
                issue_op = op; issue_a = a; issue_b = b; issue_rd = rd;
            end else begin
                issue_op = 1'($urandom_range(0, 1)); issue_a = $urandom; issue_b = $urandom;
                issue_rd = 5'($urandom_range(0, 31));
            end
            rdy_now      = (p == P_WAIT) && (wcnt == lat);
            md_resultRDY = rdy_now || (p == P_START && stale);
            md_result    = rdy_now ? exp_data : $urandom;
            md_exception = rdy_now ? mexc : 1'($urandom_range(0, 1));
            wb_ack       = (p == P_DONE) && (dcnt == ack_delay + 1);
            flush        = 1'b0;
            dep_rs1      = fix_dep ? rs_fix : rnd_rs(rd);
            dep_rs2      = fix_dep ? 5'd31  : rnd_rs(rd);
            #1;
            exp_rdy   = (p == P_ACC);
            busy      = (p != P_ACC);
            exp_haz   = busy && (rd != 0) && (dep_rs1 == rd || dep_rs2 == rd);
            exp_stall = (issue_valid && !exp_rdy) || exp_haz;
            checks++;
            if (o_ready !== exp_rdy || o_wbv !== (p == P_DONE) ||
                o_mult !== (p == P_START && !op) || o_div !== (p == P_START && op)) begin
                failures++;
                $display("FAIL ctrl t=%0t phase=%0d: ready=%b wb_valid=%b mult=%b div=%b, expected %b %b %b %b",
                         $time, p, o_ready, o_wbv, o_mult, o_div, exp_rdy, (p == P_DONE),
                         (p == P_START && !op), (p == P_START && op));
            end
            checks++;
            if (o_haz !== exp_haz || o_stall !== exp_stall) begin
                failures++;
                $display("FAIL hazard t=%0t phase=%0d rd=%0d rs1=%0d rs2=%0d: dep_hazard=%b stall=%b, expected %b %b",
                         $time, p, rd, dep_rs1, dep_rs2, o_haz, o_stall, exp_haz, exp_stall);
            end
            if (p == P_START || p == P_WAIT) begin
                checks++;
                if (o_opa !== a || o_opb !== b) begin
                    failures++;
                    $display("FAIL operands t=%0t: A=%h B=%h, expected A=%h B=%h", $time, o_opa, o_opb, a, b);
                end
            end
            if (p == P_DONE) begin
                checks++;
                if (o_wbrd !== rd || o_wbdata !== exp_data || o_wbexc !== exp_exc) begin
                    failures++;
                    $display("FAIL wb_payload t=%0t: rd=%0d data=%h exc=%b, expected rd=%0d data=%h exc=%b",
                             $time, o_wbrd, o_wbdata, o_wbexc, rd, exp_data, exp_exc);
                end
            end
        end
        step();
        wb_ack = 1'b0;
        issue_valid = 1'b0;
        md_resultRDY = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet_inputs();
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            checks++;
            if (o_ready !== 1'b1 || o_haz !== 1'b0 || o_stall !== 1'b0 || o_opa !== 0 || o_opb !== 0 ||
                o_mult !== 1'b0 || o_div !== 1'b0 || o_wbv !== 1'b0 || o_wbrd !== 0 || o_wbdata !== 0 ||
                o_wbexc !== 1'b0) begin
                failures++;
                $display("FAIL reset_state inst=%0d: ready=%b haz=%b stall=%b A=%h B=%h mult=%b div=%b wbv=%b rd=%0d data=%h exc=%b, expected ready=1 others 0",
                         s, o_ready, o_haz, o_stall, o_opa, o_opb, o_mult, o_div, o_wbv, o_wbrd, o_wbdata, o_wbexc);
            end
        end
        sel = 1'b0;
        reset = 1'b0;
        step();
        // reset mid-op
        issue_valid = 1'b1; issue_op = 1'b0; issue_a = 32'd9; issue_b = 32'd9; issue_rd = 5'd6;
        step();
        issue_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_opa !== 0 || o_opb !== 0 || o_mult !== 1'b0 || o_div !== 1'b0 ||
            o_wbv !== 1'b0 || o_wbrd !== 0 || o_wbdata !== 0 || o_wbexc !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop: ready=%b A=%h B=%h mult=%b div=%b wbv=%b rd=%0d, expected ready=1 others 0",
                     o_ready, o_opa, o_opb, o_mult, o_div, o_wbv, o_wbrd);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_mult !== 1'b0 || o_div !== 1'b0 || o_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_nopulse cyc=%0d: mult=%b div=%b ready=%b, expected 0 0 1", i, o_mult, o_div, o_ready);
            end
        end
    endtask

    task automatic test_mult();
        do_op(1'b0, 32'd7, 32'd3, 5'd4, 33, 1'b0, 2, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_back_to_back();
        do_op(1'b1, 32'd7, 32'd3, 5'd9, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 5'd0);
        do_op(1'b0, 32'd12, 32'd11, 5'd2, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 5'd0);
        do_op(1'b1, 32'd100, 32'd9, 5'd3, 1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 5'd0);
    endtask

    task automatic test_div_zero();
        do_op(1'b1, 32'd5, 32'd0, 5'd12, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
        do_op(1'b1, 32'd5, 32'd0, 5'd13, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
        do_op(1'b0, 32'd5, 32'd0, 5'd14, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_hazard();
        do_op(1'b0, 32'd11, 32'd2, 5'd5, 6, 1'b0, 1, 1'b0, 1'b0, 1'b1, 5'd5);
        do_op(1'b0, 32'd11, 32'd2, 5'd0, 6, 1'b0, 1, 1'b0, 1'b0, 1'b1, 5'd0);
    endtask

    task automatic test_timeout();
        apply_reset();
        sel = 1'b1;
        do_op(1'b0, 32'd4, 32'd5, 5'd8, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 5'd0);
        do_op(1'b1, 32'd100, 32'd7, 5'd3, T_SMALL, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
        do_op(1'b0, 32'd6, 32'd6, 5'd3, T_SMALL + 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
        apply_reset();
        sel = 1'b0;
        do_op(1'b0, 32'd6, 32'd7, 5'd2, T_MAIN, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
        do_op(1'b0, 32'd6, 32'd7, 5'd2, T_MAIN + 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_flush();
        int n;
        bit saw_wb;
        quiet_inputs();
        // flush while waiting on multdiv
        issue_valid = 1'b1; issue_a = 32'd3; issue_b = 32'd4; issue_rd = 5'd3;
        step();
        issue_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        dep_rs1 = 5'd3;
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_wbv !== 1'b0 || o_haz !== 1'b0 || o_mult !== 1'b0 || o_div !== 1'b0) begin
            failures++;
            $display("FAIL flush_drain: ready=%b wbv=%b haz=%b mult=%b div=%b, expected all 0",
                     o_ready, o_wbv, o_haz, o_mult, o_div);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_in_drain: ready=%b, expected 0", o_ready);
        end
        md_resultRDY = 1'b1; md_result = 32'd12;
        step();
        md_resultRDY = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_wbv !== 1'b0) begin
            failures++;
            $display("FAIL flush_exit: ready=%b wbv=%b, expected 1 0", o_ready, o_wbv);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_wbv !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_wb cyc=%0d: wbv=%b, expected 0", i, o_wbv);
            end
        end
        // flush beats issue_valid in IDLE
        issue_valid = 1'b1; issue_op = 1'b1; issue_a = 32'd8; issue_b = 32'd2; issue_rd = 5'd4; flush = 1'b1;
        step();
        issue_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_ready !== 1'b1 || o_mult !== 1'b0 || o_div !== 1'b0) begin
                failures++;
                $display("FAIL flush_beats_issue cyc=%0d: ready=%b mult=%b div=%b, expected 1 0 0", i, o_ready, o_mult, o_div);
            end
            step();
        end
        // flush in DONE drops the writeback
        issue_valid = 1'b1; issue_op = 1'b1; issue_a = 32'd5; issue_b = 32'd0; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        checks++;
        if (o_wbv !== 1'b1) begin
            failures++;
            $display("FAIL flush_done_pre: wbv=%b, expected 1", o_wbv);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (o_wbv !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done: wbv=%b ready=%b, expected 0 1", o_wbv, o_ready);
        end
        // flush in START on the short-timeout unit: DRAIN must end by timeout
        apply_reset();
        sel = 1'b1;
        issue_valid = 1'b1; issue_op = 1'b0; issue_a = 32'd2; issue_b = 32'd2; issue_rd = 5'd1;
        step();
        issue_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n = 0;
        saw_wb = 1'b0;
        while (o_ready !== 1'b1 && n <= T_SMALL + 2) begin
            if (o_wbv === 1'b1) saw_wb = 1'b1;
            step();
            n++;
        end
        checks++;
        if (n < 1 || n > T_SMALL || saw_wb) begin
            failures++;
            $display("FAIL drain_timeout: drain_cycles=%0d wb_seen=%b, expected 1..%0d cycles and no wb", n, saw_wb, T_SMALL);
        end
        apply_reset();
        sel = 1'b0;
    endtask

    task automatic test_random();
        bit op;
        logic [31:0] b;
        int gap;
        apply_reset();
        sel = 1'b0;
        for (int it = 0; it < 25; it++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                issue_valid = 1'b0;
                dep_rs1 = 5'($urandom_range(0, 31));
                dep_rs2 = 5'($urandom_range(0, 31));
                #1;
                checks++;
                if (o_ready !== 1'b1 || o_haz !== 1'b0 || o_stall !== 1'b0 || o_wbv !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_gap it=%0d: ready=%b haz=%b stall=%b wbv=%b, expected 1 0 0 0",
                             it, o_ready, o_haz, o_stall, o_wbv);
                end
                step();
            end
            op = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            do_op(op, $urandom, b, 5'($urandom_range(0, 31)), $urandom_range(1, 70),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 5'd0);
        end
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_wbv !== 1'b0) begin
            failures++;
            $display("FAIL final_idle: ready=%b wbv=%b, expected 1 0", o_ready, o_wbv);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        quiet_inputs();
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_zero();
        test_hazard();
        test_timeout();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
